// File: rtl/uart_rx_read_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx_pkg : shared types and field positions for the UART Rx read sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_RDY = 3'd1,
    ST_ORDER    = 3'd2,
    ST_CAPTURE  = 3'd3,
    ST_RESP     = 3'd4,
    ST_HOLD     = 3'd5
  } rx_state_t;

  localparam int unsigned ERR_PE = 3;
  localparam int unsigned ERR_FE = 2;
  localparam int unsigned ERR_BE = 1;
  localparam int unsigned ERR_OE = 0;

  // FIFO word layout: {FE,BE,OE,parity,data[7:0]}
  localparam int unsigned DATA_MSB = 7;
  localparam int unsigned PAR_BIT  = 8;
  localparam int unsigned ERR_LSB  = 9;

  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_timeout_cnt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx_timeout_cnt : saturating wait counter with clear, enable, expired flag
// Rev 1.0
// ---------------------------------------------------------------------------
module uart_rx_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TO_W-1:0] c_LIMIT = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  // Parks at the limit so a stalled FIFO can never wrap back into a long wait.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != c_LIMIT)) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/uart_rx_read_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx_read_ctrl : turns an APB read request into the Rx FIFO pop sequence
// and captures one word. Optional even-parity check: UART_RX_PARITY_CHK_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
module uart_rx_read_ctrl
  import uart_rx_pkg::*;
#(
  parameter int FIFO_WIDTH_R   = 12,
  parameter int ORDER_LEN      = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 10
) (
  input  logic                    baud_clk,
  input  logic                    rst,
  input  logic                    rd_req,
  input  logic                    rx_ready,
  input  logic                    rx_empty,
  input  logic [FIFO_WIDTH_R-1:0] rx_word,
  output logic                    receive_order,
  output logic                    new_instruction_rx,
  output logic                    rd_ack,
  output logic [7:0]              rd_data,
  output logic                    rd_parity,
  output logic [3:0]              err_status,
  input  logic                    err_clr,
  output logic                    timeout,
  output logic                    irq
);

  localparam int c_OC_W = (ORDER_LEN > 1) ? $clog2(ORDER_LEN) : 1;
  localparam logic [c_OC_W-1:0] c_ORD_LAST = c_OC_W'(ORDER_LEN - 1);

  rx_state_t         state_q, state_d;
  logic [c_OC_W-1:0] ord_q, ord_d;
  logic [7:0]        data_q, data_d;
  logic              par_q, par_d;
  logic              to_q, to_d;
  logic [3:0]        err_q, err_d;
  logic              irq_q, irq_d;

  logic w_to_clr;
  logic w_to_en;
  logic w_to_expired;
  logic w_capture;
  logic w_abort;
  logic w_pe;

  uart_rx_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_timeout_cnt (
    .clk    (baud_clk),
    .rst    (rst),
    .clr    (w_to_clr),
    .en     (w_to_en),
    .expired(w_to_expired)
  );

  always_comb begin
    state_d            = state_q;
    ord_d              = '0;
    w_to_clr           = 1'b0;
    w_to_en            = 1'b0;
    w_capture          = 1'b0;
    w_abort            = 1'b0;
    receive_order      = 1'b0;
    rd_ack             = 1'b0;
    new_instruction_rx = 1'b0;
    case (state_q)
      ST_IDLE: begin
        w_to_clr = 1'b1;
        if (rd_req) state_d = ST_WAIT_RDY;
      end
      ST_WAIT_RDY: begin
        w_to_en = 1'b1;
        if (rx_ready && !rx_empty) begin
          state_d = ST_ORDER;
        end else if (w_to_expired) begin
          state_d = ST_RESP;
          w_abort = 1'b1;
        end
      end
      // Every extra cycle with receive_order high pops another word.
      ST_ORDER: begin
        receive_order = 1'b1;
        if (ord_q == c_ORD_LAST) begin
          state_d = ST_CAPTURE;
        end else begin
          ord_d = ord_q + c_OC_W'(1);
        end
      end
      ST_CAPTURE: begin
        w_capture = 1'b1;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        rd_ack  = 1'b1;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        new_instruction_rx = rd_req;
        if (!rd_req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_CHK_EN
  assign w_pe = even_parity(rx_word[DATA_MSB:0]) != rx_word[PAR_BIT];
`else
  assign w_pe = 1'b0;
`endif

  always_comb begin
    data_d = data_q;
    par_d  = par_q;
    to_d   = to_q;
    err_d  = err_clr ? 4'b0000 : err_q;
    if (w_capture) begin
      data_d = rx_word[DATA_MSB:0];
      par_d  = rx_word[PAR_BIT];
      to_d   = 1'b0;
      // Applied after the clear so a same-cycle new error survives err_clr.
      err_d[ERR_FE] = err_d[ERR_FE] | rx_word[ERR_LSB+2];
      err_d[ERR_BE] = err_d[ERR_BE] | rx_word[ERR_LSB+1];
      err_d[ERR_OE] = err_d[ERR_OE] | rx_word[ERR_LSB];
      err_d[ERR_PE] = err_d[ERR_PE] | w_pe;
    end else if (w_abort) begin
      data_d = 8'h00;
      par_d  = 1'b0;
      to_d   = 1'b1;
    end
    irq_d = |err_q;
  end

  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ord_q   <= '0;
      data_q  <= 8'h00;
      par_q   <= 1'b0;
      to_q    <= 1'b0;
      err_q   <= 4'b0000;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ord_q   <= ord_d;
      data_q  <= data_d;
      par_q   <= par_d;
      to_q    <= to_d;
      err_q   <= err_d;
      irq_q   <= irq_d;
    end
  end

  assign rd_data    = data_q;
  assign rd_parity  = par_q;
  assign timeout    = to_q;
  assign err_status = err_q;
  assign irq        = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_read_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_rx_read_ctrl : directed + randomized read transactions against a
// transaction-level model of the read sequencer. Rev 1.0
// ---------------------------------------------------------------------------
module tb_uart_rx_read_ctrl;

  localparam int ORDER_LEN = 2;
  localparam int TMO       = 16;

  logic        baud_clk = 1'b0;
  logic        rst;
  logic        rd_req;
  logic        rx_ready;
  logic        rx_empty;
  logic [11:0] rx_word;
  logic        receive_order;
  logic        new_instruction_rx;
  logic        rd_ack;
  logic [7:0]  rd_data;
  logic        rd_parity;
  logic [3:0]  err_status;
  logic        err_clr;
  logic        timeout;
  logic        irq;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_err = 4'b0000;

  uart_rx_read_ctrl #(
    .FIFO_WIDTH_R  (12),
    .ORDER_LEN     (ORDER_LEN),
    .TIMEOUT_CYCLES(TMO),
    .TO_W          (4)
  ) dut (
    .baud_clk          (baud_clk),
    .rst               (rst),
    .rd_req            (rd_req),
    .rx_ready          (rx_ready),
    .rx_empty          (rx_empty),
    .rx_word           (rx_word),
    .receive_order     (receive_order),
    .new_instruction_rx(new_instruction_rx),
    .rd_ack            (rd_ack),
    .rd_data           (rd_data),
    .rd_parity         (rd_parity),
    .err_status        (err_status),
    .err_clr           (err_clr),
    .timeout           (timeout),
    .irq               (irq)
  );

  always #5 baud_clk = ~baud_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] word_errors(input logic [11:0] w);
    logic pe;
`ifdef UART_RX_PARITY_CHK_EN
    pe = (^w[7:0]) != w[8];
`else
    pe = 1'b0;
`endif
    return {pe, w[11:9]};
  endfunction

  function automatic logic [11:0] rand_word();
    logic [2:0] e;
    e = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
    return {e, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255))};
  endfunction

  // d < 0 : FIFO never becomes ready (timeout). d >= 0 : ready d cycles after rd_req.
  task automatic do_read(input logic [11:0] word, input int d, input bit early,
                         input bit clr_cap, input int h);
    int cyc;
    int orders;
    int ni;
    int lat;
    int wait_cyc;
    bit got;
    bit to;
    logic [7:0] edata;
    logic       epar;
    to       = (d < 0);
    wait_cyc = (d > 1) ? d - 1 : 0;
    lat      = to ? 1 + TMO : 1 + wait_cyc + ORDER_LEN + 2;
    cyc = 0; orders = 0; ni = 0; got = 1'b0;
    rx_word  = word;
    rx_ready = (d == 0);
    rx_empty = (d != 0);
    rd_req   = 1'b1;
    while (!got && cyc < 64) begin
      @(negedge baud_clk);
      cyc++;
      if (receive_order) orders++;
      if (new_instruction_rx) ni++;
      got = rd_ack;
      if (!got) begin
        if (cyc == d) begin
          rx_ready = 1'b1;
          rx_empty = 1'b0;
        end
        if (early && cyc == 2) rd_req = 1'b0;
        err_clr = clr_cap && (cyc == lat - 1);
      end
    end
    err_clr = 1'b0;
    check("ack_seen", 32'(got), 32'd1);
    check("ack_latency", 32'(cyc), 32'(lat));
    check("order_cycles", 32'(orders), to ? 32'd0 : 32'(ORDER_LEN));
    check("newinstr_before_hold", 32'(ni), 32'd0);
    edata = to ? 8'h00 : word[7:0];
    epar  = to ? 1'b0 : word[8];
    if (!to) exp_err = clr_cap ? word_errors(word) : (exp_err | word_errors(word));
    check("rd_data", 32'(rd_data), 32'(edata));
    check("rd_parity", 32'(rd_parity), 32'(epar));
    check("timeout", 32'(timeout), 32'(to));
    check("err_status", 32'(err_status), 32'(exp_err));
    rx_ready = 1'b0;
    rx_empty = 1'b1;
    @(negedge baud_clk);
    check("ack_one_cycle", 32'(rd_ack), 32'd0);
    check("irq", 32'(irq), 32'(|exp_err));
    check("rd_data_hold", 32'(rd_data), 32'(edata));
    if (!early) begin
      check("newinstr_hold", 32'(new_instruction_rx), 32'd1);
      for (int i = 1; i < h; i++) begin
        @(negedge baud_clk);
        check("newinstr_hold", 32'(new_instruction_rx), 32'd1);
        check("no_extra_order", 32'(receive_order), 32'd0);
      end
      rd_req = 1'b0;
      #1;
      check("newinstr_drop", 32'(new_instruction_rx), 32'd0);
    end else begin
      check("newinstr_early", 32'(new_instruction_rx), 32'd0);
    end
    @(negedge baud_clk);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge baud_clk);
    exp_err = 4'b0000;
    check("err_clr_status", 32'(err_status), 32'd0);
    err_clr = 1'b0;
    @(negedge baud_clk);
    check("err_clr_irq", 32'(irq), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rd_req = 1'b0; rx_ready = 1'b0; rx_empty = 1'b1;
    rx_word = 12'h000; err_clr = 1'b0;
    repeat (2) @(negedge baud_clk);
    check("rst_order", 32'(receive_order), 32'd0);
    check("rst_ack", 32'(rd_ack), 32'd0);
    check("rst_newinstr", 32'(new_instruction_rx), 32'd0);
    check("rst_data", 32'(rd_data), 32'd0);
    check("rst_err", 32'(err_status), 32'd0);
    check("rst_irq_timeout", 32'({irq, timeout}), 32'd0);
    rst = 1'b0;
    @(negedge baud_clk);

    // Clean word, FIFO already ready
    do_read({3'b000, 1'b0, 8'hA5}, 0, 1'b0, 1'b0, 1);
    // Framing error, then clear
    do_read({3'b100, 1'b0, 8'h3C}, 0, 1'b0, 1'b0, 2);
    pulse_clr();
    // FIFO never ready
    do_read(12'hBAD, -1, 1'b0, 1'b0, 1);
    // Parity mismatch word
    do_read({3'b000, 1'b0, 8'h01}, 0, 1'b0, 1'b0, 1);
    pulse_clr();
    // Request dropped before response
    do_read(rand_word(), 3, 1'b1, 1'b0, 1);
    // Clear coinciding with capture of a new error
    do_read({3'b001, 1'b1, 8'h77}, 0, 1'b0, 1'b0, 1);
    do_read({3'b100, 1'b1, 8'h11}, 2, 1'b0, 1'b1, 1);
    pulse_clr();

    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 5) == 0) pulse_clr();
      do_read(rand_word(), int'($urandom_range(0, 8)), ($urandom_range(0, 4) == 0),
              1'b0, int'($urandom_range(1, 3)));
    end

    // Asynchronous reset in the middle of the pop sequence
    do_read({3'b010, 1'b0, 8'h5A}, 0, 1'b0, 1'b0, 1);
    rx_word = 12'h0C3; rx_ready = 1'b1; rx_empty = 1'b0; rd_req = 1'b1;
    repeat (2) @(negedge baud_clk);
    check("pre_rst_order", 32'(receive_order), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_order", 32'(receive_order), 32'd0);
    check("rst_mid_err", 32'(err_status), 32'd0);
    check("rst_mid_data", 32'(rd_data), 32'd0);
    check("rst_mid_ack", 32'(rd_ack), 32'd0);
    exp_err = 4'b0000;
    @(negedge baud_clk);
    rst = 1'b0; rd_req = 1'b0; rx_ready = 1'b0; rx_empty = 1'b1;
    @(negedge baud_clk);
    do_read({3'b000, 1'b1, 8'hE7}, 1, 1'b0, 1'b0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
